vram_bus_arbiter: RTL and testbench
===================================

VRAM_BUS_ARBITER -- requirements
Module: vram_bus_arbiter

Interface
REQ-001 SHALL have ports, one per line (name, direction, width, meaning):
- clk1  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ppu_req  in  1  PPU fetch request.
- ppu_addr  in  13  PPU fetch address.
- dma_req  in  1  OAM-DMA source read from VRAM.
- dma_addr  in  13  DMA address.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write when 1, read when 0.
- cpu_addr  in  13  CPU address.
- cpu_wdata  in  8  CPU write data.
- vram_lock  in  1  PPU mode-3 lock; CPU access forbidden.
- md_in  in  8  VRAM data bus input.
- ma  out  13  VRAM address.
- md_out  out  8  VRAM write data.
- md_oe  out  1  drive md_out onto the bus.
- mcs  out  1  chip select.
- moe  out  1  output enable (read strobe).
- mwr  out  1  write strobe.
- ppu_ack, dma_ack, cpu_ack  out  1 each  one-cycle completion pulses.
- rdata  out  8  last read result.
- busy  out  1  high when state is not IDLE.
REQ-002 SHALL use the single clock clk1 and a synchronous, active-high reset named reset. No other clocks, no asynchronous logic.
REQ-003 SHALL drive every output from a register; no combinational input-to-output paths.

Function
REQ-004 SHALL implement states IDLE, SETUP, STROBE and REJECT.
REQ-005 SHALL arbitrate with fixed priority PPU > DMA > CPU, evaluated in IDLE and on the last cycle of STROBE.
REQ-006 SHALL, on a grant, latch the owner, address, we flag (PPU/DMA always read) and wdata, then enter SETUP.
REQ-007 SETUP (1 cycle): ma=latched addr; mcs=1; moe=0; mwr=0; md_oe=we; md_out=wdata when we=1.
REQ-008 STROBE (1 cycle): ma and mcs held; moe=!we; mwr=we; md_oe=we; the owner's ack=1.
REQ-009 SHALL, at the end of STROBE on a read, capture md_in into rdata. rdata becomes valid in the cycle after STROBE and holds until the next read capture or REJECT.
REQ-010 SHALL keep rdata unchanged on writes.
REQ-011 SHALL exclude the current owner's request from the arbitration at the end of STROBE, so the request is treated as consumed.
- The requester drops its req on seeing ack.
- A req still high on the following cycle is a new access.
REQ-012 SHALL go from STROBE directly to SETUP when another request wins (back-to-back, 1 access per 2 cycles). Otherwise it returns to IDLE with mcs, moe, mwr and md_oe low.
REQ-013 Latency: req sampled high in IDLE at edge E0 -> SETUP in cycle E0+1, STROBE/ack in E0+2, rdata valid in E0+3.
REQ-014 SHALL, when the CPU is the winner and vram_lock=1, enter REJECT for 1 cycle. In REJECT:
- cpu_ack=1 and rdata=0xFF.
- mcs, moe, mwr and md_oe stay 0.
- A write is discarded.
- Next state is IDLE, or SETUP if a PPU or DMA request is pending.
REQ-015 SHALL apply vram_lock only at grant time. A CPU slot already in SETUP or STROBE completes normally if vram_lock rises.
REQ-016 SHALL never assert moe and mwr together, never assert either without mcs, and never assert more than one ack in a cycle.
REQ-017 Simultaneous requests: the lower-priority requester waits with req held. Strict priority is intended; a continuous PPU request may starve DMA and CPU.
REQ-018 SHALL ignore requester address and data changes after the grant latch, and treat the 13-bit addresses as opaque (no wrap or range check).

Reset
REQ-019 SHALL, while reset=1 at a clock edge, set the following, taking effect the next cycle and aborting any slot in progress without an ack:
- state=IDLE
- ma=0, md_out=0
- md_oe=0, mcs=0, moe=0, mwr=0
- all acks=0, busy=0
- rdata=0xFF
REQ-020 SHALL ignore all requests while reset=1 and begin arbitrating on the first edge with reset=0.

Verification
REQ-021 CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x0123, vram_lock=0, md_in=0x5A.
- Expect ma=0x0123 with mcs in E0+1 and E0+2.
- Expect moe only in E0+2, with cpu_ack in E0+2.
- Expect rdata=0x5A from E0+3.
REQ-022 CPU write: cpu_addr=0x1FFF, cpu_wdata=0xC3.
- Expect md_oe=1 and md_out=0xC3 in E0+1 and E0+2.
- Expect mwr only in E0+2, with moe=0 throughout.
- Expect rdata unchanged.
REQ-023 Contention: ppu_req, dma_req and cpu_req rise together.
- Expect acks in the order PPU (E0+2), DMA (E0+4), CPU (E0+6).
- Expect no IDLE cycle between the three slots.
REQ-024 Lock: vram_lock=1 with a CPU read.
- Expect cpu_ack in E0+1 and rdata=0xFF.
- Expect no mcs.
- A CPU write under the same lock produces no mwr.
REQ-025 Reset mid-slot: assert reset in the SETUP cycle of a DMA read.
- Expect all strobes 0 next cycle, no dma_ack, busy=0 and rdata=0xFF.
- After release, a held dma_req is regranted with the REQ-013 latency.

Source files
------------

// File: rtl/vram_bus_arbiter.sv
// VRAM bus arbiter: fixed-priority PPU > DMA > CPU, two-cycle SETUP/STROBE slots,
// single-cycle REJECT for CPU accesses attempted while the PPU holds the VRAM lock.
module vram_bus_arbiter (
    input  logic        clk1,
    input  logic        reset,
    input  logic        ppu_req,
    input  logic [12:0] ppu_addr,
    input  logic        dma_req,
    input  logic [12:0] dma_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        vram_lock,
    input  logic [7:0]  md_in,
    output logic [12:0] ma,
    output logic [7:0]  md_out,
    output logic        md_oe,
    output logic        mcs,
    output logic        moe,
    output logic        mwr,
    output logic        ppu_ack,
    output logic        dma_ack,
    output logic        cpu_ack,
    output logic [7:0]  rdata,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_REJECT} state_t;

    localparam logic [1:0] OWN_PPU  = 2'd0;
    localparam logic [1:0] OWN_DMA  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_NONE = 2'd3;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_owner;
    logic [12:0] r_addr;
    logic        r_we;
    logic [7:0]  r_wdata;

    logic [12:0] r_ma,      w_ma_next;
    logic [7:0]  r_md_out,  w_md_out_next;
    logic        r_md_oe,   w_md_oe_next;
    logic        r_mcs,     w_mcs_next;
    logic        r_moe,     w_moe_next;
    logic        r_mwr,     w_mwr_next;
    logic        r_ppu_ack, w_ppu_ack_next;
    logic        r_dma_ack, w_dma_ack_next;
    logic        r_cpu_ack, w_cpu_ack_next;
    logic [7:0]  r_rdata,   w_rdata_next;
    logic        r_busy,    w_busy_next;

    logic        w_arb_en;
    logic        w_excl;
    logic        w_ppu_cand;
    logic        w_dma_cand;
    logic        w_cpu_cand;
    logic [1:0]  w_win;
    logic        w_grant;
    logic        w_reject;
    logic [12:0] w_sel_addr;
    logic        w_sel_we;
    logic [7:0]  w_sel_wdata;

    // The slot that just finished (STROBE or REJECT) must not win again this edge.
    assign w_arb_en   = (r_state == S_IDLE) || (r_state == S_STROBE) || (r_state == S_REJECT);
    assign w_excl     = (r_state == S_STROBE) || (r_state == S_REJECT);
    assign w_ppu_cand = ppu_req && !(w_excl && (r_owner == OWN_PPU));
    assign w_dma_cand = dma_req && !(w_excl && (r_owner == OWN_DMA));
    assign w_cpu_cand = cpu_req && !(w_excl && (r_owner == OWN_CPU));
    assign w_win      = w_ppu_cand ? OWN_PPU :
                        w_dma_cand ? OWN_DMA :
                        w_cpu_cand ? OWN_CPU : OWN_NONE;
    assign w_grant    = w_arb_en && (w_win != OWN_NONE);
    assign w_reject   = w_grant && (w_win == OWN_CPU) && vram_lock;

    always_comb begin
        w_sel_addr  = cpu_addr;
        w_sel_we    = 1'b0;
        w_sel_wdata = cpu_wdata;
        unique case (w_win)
            OWN_PPU: w_sel_addr = ppu_addr;
            OWN_DMA: w_sel_addr = dma_addr;
            OWN_CPU: w_sel_we   = cpu_we;
            default: ;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= OWN_NONE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_owner <= w_win;
                r_addr  <= w_sel_addr;
                r_we    <= w_sel_we;
                r_wdata <= w_sel_wdata;
            end
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        unique case (r_state)
            S_SETUP: w_state_next = S_STROBE;
            default: begin
                if (w_grant)
                    w_state_next = w_reject ? S_REJECT : S_SETUP;
                else
                    w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are computed for the upcoming state so every port comes straight from a flop.
    always_comb begin
        w_ma_next      = r_ma;
        w_md_out_next  = r_md_out;
        w_md_oe_next   = 1'b0;
        w_mcs_next     = 1'b0;
        w_moe_next     = 1'b0;
        w_mwr_next     = 1'b0;
        w_ppu_ack_next = 1'b0;
        w_dma_ack_next = 1'b0;
        w_cpu_ack_next = 1'b0;
        w_busy_next    = (w_state_next != S_IDLE);
        w_rdata_next   = r_rdata;
        if ((r_state == S_STROBE) && !r_we)
            w_rdata_next = md_in;
        unique case (w_state_next)
            S_SETUP: begin
                w_ma_next    = w_sel_addr;
                w_mcs_next   = 1'b1;
                w_md_oe_next = w_sel_we;
                if (w_sel_we)
                    w_md_out_next = w_sel_wdata;
            end
            S_STROBE: begin
                w_ma_next      = r_addr;
                w_mcs_next     = 1'b1;
                w_moe_next     = !r_we;
                w_mwr_next     = r_we;
                w_md_oe_next   = r_we;
                w_ppu_ack_next = (r_owner == OWN_PPU);
                w_dma_ack_next = (r_owner == OWN_DMA);
                w_cpu_ack_next = (r_owner == OWN_CPU);
            end
            S_REJECT: begin
                w_cpu_ack_next = 1'b1;
                w_rdata_next   = 8'hFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_ma      <= '0;
            r_md_out  <= '0;
            r_md_oe   <= 1'b0;
            r_mcs     <= 1'b0;
            r_moe     <= 1'b0;
            r_mwr     <= 1'b0;
            r_ppu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_rdata   <= 8'hFF;
            r_busy    <= 1'b0;
        end else begin
            r_ma      <= w_ma_next;
            r_md_out  <= w_md_out_next;
            r_md_oe   <= w_md_oe_next;
            r_mcs     <= w_mcs_next;
            r_moe     <= w_moe_next;
            r_mwr     <= w_mwr_next;
            r_ppu_ack <= w_ppu_ack_next;
            r_dma_ack <= w_dma_ack_next;
            r_cpu_ack <= w_cpu_ack_next;
            r_rdata   <= w_rdata_next;
            r_busy    <= w_busy_next;
        end
    end

    assign ma      = r_ma;
    assign md_out  = r_md_out;
    assign md_oe   = r_md_oe;
    assign mcs     = r_mcs;
    assign moe     = r_moe;
    assign mwr     = r_mwr;
    assign ppu_ack = r_ppu_ack;
    assign dma_ack = r_dma_ack;
    assign cpu_ack = r_cpu_ack;
    assign rdata   = r_rdata;
    assign busy    = r_busy;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Bench for vram_bus_arbiter: directed scenarios then random traffic, all checked
// against a slot-timeline model that schedules expected bus cycles per grant.
module tb_vram_bus_arbiter;

    logic        clk1 = 1'b0;
    logic        reset;
    logic        ppu_req, dma_req, cpu_req, cpu_we, vram_lock;
    logic [12:0] ppu_addr, dma_addr, cpu_addr;
    logic [7:0]  cpu_wdata, md_in;
    logic [12:0] ma;
    logic [7:0]  md_out, rdata;
    logic        md_oe, mcs, moe, mwr, ppu_ack, dma_ack, cpu_ack, busy;

    always #5 clk1 = ~clk1;

    vram_bus_arbiter dut (
        .clk1(clk1), .reset(reset),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr),
        .dma_req(dma_req), .dma_addr(dma_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .vram_lock(vram_lock), .md_in(md_in),
        .ma(ma), .md_out(md_out), .md_oe(md_oe), .mcs(mcs), .moe(moe), .mwr(mwr),
        .ppu_ack(ppu_ack), .dma_ack(dma_ack), .cpu_ack(cpu_ack),
        .rdata(rdata), .busy(busy)
    );

    // Expected bus picture for one cycle; cycle n is the one that starts at edge n.
    typedef struct {
        bit        mcs, moe, mwr, mdoe, busy;
        bit [2:0]  ack;      // {cpu, dma, ppu}
        bit [12:0] ma;
        bit [7:0]  mdo;
        bit        chk_ma, chk_mdo, rdcap;
        bit [7:0]  rdata;
    } exp_t;

    localparam int NCYC = 4000;
    exp_t     ex [NCYC];
    int       n;
    int       last_busy;
    int       last_owner;
    bit [7:0] rd_m;
    int       n_chk;
    int       n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n, obs, exp_v);
        end
    endtask

    // Decide what the bus must do from this edge on, using the inputs about to be sampled.
    task automatic model_edge();
        exp_t     e0;
        bit [2:0] cand;
        int       w;
        bit       we;
        e0 = '{default: 0};
        if (reset) begin
            ex[n] = e0;
            ex[n].chk_ma = 1'b1;
            ex[n].chk_mdo = 1'b1;
            rd_m = 8'hFF;
            ex[n].rdata = rd_m;
            last_busy = n;
            last_owner = -1;
            return;
        end
        if (n > 0 && ex[n-1].rdcap) rd_m = md_in;
        if (last_busy < n) begin
            ex[n] = e0;
            cand = {cpu_req, dma_req, ppu_req};
            if (last_busy == n - 1 && last_owner >= 0) cand[last_owner] = 1'b0;
            w = cand[0] ? 0 : cand[1] ? 1 : cand[2] ? 2 : -1;
            if (w == 2 && vram_lock) begin
                ex[n].busy = 1'b1;
                ex[n].ack = 3'b100;
                rd_m = 8'hFF;
                last_busy = n;
                last_owner = 2;
            end else if (w >= 0) begin
                we = (w == 2) && cpu_we;
                ex[n].mcs = 1'b1;
                ex[n].busy = 1'b1;
                ex[n].ma = (w == 0) ? ppu_addr : (w == 1) ? dma_addr : cpu_addr;
                ex[n].chk_ma = 1'b1;
                ex[n].mdoe = we;
                ex[n].mdo = cpu_wdata;
                ex[n].chk_mdo = we;
                ex[n+1] = ex[n];
                ex[n+1].moe = !we;
                ex[n+1].mwr = we;
                ex[n+1].ack[w] = 1'b1;
                ex[n+1].rdcap = !we;
                last_busy = n + 1;
                last_owner = w;
            end
        end
        ex[n].rdata = rd_m;
    endtask

    task automatic check_cycle();
        exp_t e;
        e = ex[n];
        chk("mcs", mcs, e.mcs);
        chk("moe", moe, e.moe);
        chk("mwr", mwr, e.mwr);
        chk("md_oe", md_oe, e.mdoe);
        chk("busy", busy, e.busy);
        chk("acks", {cpu_ack, dma_ack, ppu_ack}, e.ack);
        chk("rdata", rdata, e.rdata);
        if (e.chk_ma) chk("ma", ma, e.ma);
        if (e.chk_mdo) chk("md_out", md_out, e.mdo);
        chk("moe_and_mwr", moe & mwr, 1'b0);
        chk("strobe_without_mcs", (moe | mwr) & !mcs, 1'b0);
        chk("multi_ack", 32'($countones({cpu_ack, dma_ack, ppu_ack})) > 32'd1, 1'b0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk1);
        @(negedge clk1);
        check_cycle();
        $display("cyc %0d rst=%0b req=%0b%0b%0b lock=%0b ma=%0h mcs=%0b moe=%0b mwr=%0b ack=%0b%0b%0b rdata=%0h",
                 n, reset, cpu_req, dma_req, ppu_req, vram_lock, ma, mcs, moe, mwr,
                 cpu_ack, dma_ack, ppu_ack, rdata);
        n++;
    endtask

    task automatic drop_acked();
        if (ex[n-1].ack[0]) ppu_req = 1'b0;
        if (ex[n-1].ack[1]) dma_req = 1'b0;
        if (ex[n-1].ack[2]) cpu_req = 1'b0;
    endtask

    initial begin
        n = 0; n_chk = 0; n_fail = 0; last_busy = -1; last_owner = -1; rd_m = 8'hFF;
        reset = 1'b1; ppu_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        vram_lock = 1'b0; ppu_addr = 13'h0; dma_addr = 13'h0; cpu_addr = 13'h0;
        cpu_wdata = 8'h0; md_in = 8'h0;
        cpu_req = 1'b1;                       // requests must be ignored during reset
        tick(); tick();
        cpu_req = 1'b0; reset = 1'b0;
        tick();

        // CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123; md_in = 8'h5A;
        tick(); tick();
        cpu_req = 1'b0;
        tick();
        chk("cpu_read_rdata", rdata, 8'h5A);

        // CPU write at top address
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'hC3; md_in = 8'h11;
        tick(); tick();
        cpu_req = 1'b0;
        tick();
        chk("cpu_write_keeps_rdata", rdata, 8'h5A);

        // Three-way contention
        ppu_req = 1'b1; ppu_addr = 13'h0AAA; dma_req = 1'b1; dma_addr = 13'h1555;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0042; md_in = 8'h77;
        for (int i = 0; i < 8; i++) begin
            tick();
            drop_acked();
        end

        // Locked CPU read, then locked CPU write
        vram_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0300;
        tick();
        chk("lock_read_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_wdata = 8'h99;
        tick(); cpu_req = 1'b0; tick();
        vram_lock = 1'b0;

        // Reset during the SETUP cycle of a DMA read, DMA request held throughout
        md_in = 8'h3C; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
        tick(); tick(); cpu_req = 1'b0; tick();
        dma_req = 1'b1; dma_addr = 13'h0777;
        tick();
        reset = 1'b1;
        tick();
        chk("reset_abort_rdata", rdata, 8'hFF);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            drop_acked();
        end

        // Random traffic with protocol-following requesters
        for (int i = 0; i < 2500; i++) begin
            md_in = 8'($urandom);
            vram_lock = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 99) == 0);
            if (ex[n-1].ack[0]) ppu_req = $urandom_range(0, 1) == 1;
            else if (!ppu_req) ppu_req = $urandom_range(0, 9) < 3;
            if (ex[n-1].ack[1]) dma_req = $urandom_range(0, 1) == 1;
            else if (!dma_req) dma_req = $urandom_range(0, 9) < 4;
            if (ex[n-1].ack[2]) cpu_req = $urandom_range(0, 1) == 1;
            else if (!cpu_req) cpu_req = $urandom_range(0, 9) < 5;
            ppu_addr = 13'($urandom);
            dma_addr = 13'($urandom);
            cpu_addr = 13'($urandom);
            cpu_wdata = 8'($urandom);
            cpu_we = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
